fpu_op_arbiter: RTL and testbench

- Shares one serial-operand FPU processing element between NREQ requesters.
- Grants requests round-robin and drives the FPU operand sequence: a start pulse with operand a, then operand b on the next cycle.
- Waits for the answer, with a timeout, and returns the result, tagged with the requester id, on a single response bus.
- Sits between the MPU tile scheduler ports and one FPU element. Only one operation is outstanding at a time.

---
 rtl/mpu_data_types.sv | 24 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/fpu_op_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_fpu_op_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_data_types.sv
// Shared MPU types: single-precision word, FPU opcodes, error value and the
// FPU arbiter state encoding.
package mpu_data_types;

   typedef logic [31:0] float_sp;

   typedef enum logic [1:0] {
      FPU_NOP      = 2'b00,
      FPU_FMA      = 2'b01,
      FPU_MULTIPLY = 2'b10,
      FPU_ADD      = 2'b11
   } fpu_op_e;

   localparam float_sp FPU_ERR_VALUE = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ARB_IDLE   = 3'd0,
      ARB_SEND_A = 3'd1,
      ARB_SEND_B = 3'd2,
      ARB_WAIT   = 3'd3,
      ARB_RESP   = 3'd4
   } fpu_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request after ptr (wrapping)
// wins; grant is one-hot, idx is its index.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] idx,
   output logic                 any
);
   localparam int IW = $clog2(N);

   // Two passes: requesters above ptr first, then wrap around from 0.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!any && req[i] && (i > int'(ptr))) begin
            any = 1'b1;
            idx = IW'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!any && req[i]) begin
            any = 1'b1;
            idx = IW'(i);
         end
      end
      gnt = any ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/fpu_op_arbiter.sv
// Shares one serial-operand FPU between NREQ requesters: round-robin grant,
// a/b operand sequencing, bounded wait for the answer, tagged response.
module fpu_op_arbiter
   import mpu_data_types::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64,
   parameter int CNTW    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*2-1:0]       req_op,
   input  logic [NREQ*32-1:0]      req_a,
   input  logic [NREQ*32-1:0]      req_b,
   output logic [NREQ-1:0]         req_ack,
   output logic                    fpu_start,
   output logic [1:0]              fpu_op,
   output logic [31:0]             fpu_float_in,
   output logic                    fpu_flush,
   input  logic [31:0]             fpu_answer,
   input  logic                    fpu_ready,
   input  logic                    fpu_error,
   output logic                    rsp_valid,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [31:0]             rsp_data,
   output logic                    rsp_err,
   output logic                    rsp_timeout,
   output logic                    busy,
   output logic [CNTW-1:0]         op_count,
   output fpu_arb_state_e          dbg_state
);
   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(TIMEOUT);

   fpu_arb_state_e  state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d, id_q, id_d;
   fpu_op_e         op_q, op_d;
   float_sp         b_q, b_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] req_ack_q, req_ack_d;
   logic            fpu_start_q, fpu_start_d, fpu_flush_q, fpu_flush_d;
   logic [1:0]      fpu_op_q, fpu_op_d;
   float_sp         fpu_float_in_q, fpu_float_in_d, rsp_data_q, rsp_data_d;
   logic            rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic            rsp_timeout_q, rsp_timeout_d, busy_q, busy_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;
   logic [CNTW-1:0] op_count_q, op_count_d;

   logic [NREQ-1:0] gnt_oh;
   logic [IDW-1:0]  gnt_idx;
   logic            gnt_any;
   fpu_op_e         sel_op;
   float_sp         sel_a, sel_b;

   rr_arbiter #(.N(NREQ)) u_rr (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (gnt_oh),
      .idx (gnt_idx),
      .any (gnt_any)
   );

   always_comb begin
      sel_op = FPU_NOP;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_oh[i]) begin
            sel_op = fpu_op_e'(req_op[i*2 +: 2]);
            sel_a  = req_a[i*32 +: 32];
            sel_b  = req_b[i*32 +: 32];
         end
      end
   end

   // Outputs are computed for the state being entered, so every port is a flop.
   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      id_d           = id_q;
      op_d           = op_q;
      b_d            = b_q;
      cnt_d          = cnt_q;
      req_ack_d      = '0;
      fpu_start_d    = 1'b0;
      fpu_op_d       = 2'b00;
      fpu_float_in_d = '0;
      fpu_flush_d    = 1'b0;
      rsp_valid_d    = 1'b0;
      rsp_id_d       = '0;
      rsp_data_d     = '0;
      rsp_err_d      = 1'b0;
      rsp_timeout_d  = 1'b0;
      op_count_d     = op_count_q;
      case (state_q)
         ARB_IDLE: begin
            if (gnt_any) begin
               ptr_d     = gnt_idx;
               id_d      = gnt_idx;
               op_d      = sel_op;
               b_d       = sel_b;
               req_ack_d = gnt_oh;
               if (sel_op == FPU_NOP) begin
                  state_d     = ARB_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_id_d    = gnt_idx;
                  op_count_d  = op_count_q + CNTW'(1);
               end else begin
                  state_d        = ARB_SEND_A;
                  fpu_start_d    = 1'b1;
                  fpu_op_d       = sel_op;
                  fpu_float_in_d = sel_a;
               end
            end
         end
         ARB_SEND_A: begin
            state_d        = ARB_SEND_B;
            fpu_op_d       = op_q;
            fpu_float_in_d = b_q;
         end
         ARB_SEND_B: begin
            state_d        = ARB_WAIT;
            cnt_d          = '0;
            fpu_op_d       = op_q;
            fpu_float_in_d = b_q;
         end
         ARB_WAIT: begin
            // A ready on the final count still counts as a normal completion.
            if (fpu_ready) begin
               state_d     = ARB_RESP;
               rsp_valid_d = 1'b1;
               rsp_id_d    = id_q;
               rsp_data_d  = fpu_error ? FPU_ERR_VALUE : fpu_answer;
               rsp_err_d   = fpu_error;
               op_count_d  = op_count_q + CNTW'(1);
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d       = ARB_RESP;
               fpu_flush_d   = 1'b1;
               rsp_valid_d   = 1'b1;
               rsp_id_d      = id_q;
               rsp_data_d    = FPU_ERR_VALUE;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               op_count_d    = op_count_q + CNTW'(1);
            end else begin
               cnt_d          = cnt_q + CW'(1);
               fpu_op_d       = op_q;
               fpu_float_in_d = b_q;
            end
         end
         ARB_RESP: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
      busy_d = (state_d != ARB_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ARB_IDLE;
         ptr_q          <= IDW'(NREQ - 1);
         id_q           <= '0;
         op_q           <= FPU_NOP;
         b_q            <= '0;
         cnt_q          <= '0;
         req_ack_q      <= '0;
         fpu_start_q    <= 1'b0;
         fpu_op_q       <= 2'b00;
         fpu_float_in_q <= '0;
         fpu_flush_q    <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_id_q       <= '0;
         rsp_data_q     <= '0;
         rsp_err_q      <= 1'b0;
         rsp_timeout_q  <= 1'b0;
         busy_q         <= 1'b0;
         op_count_q     <= '0;
      end else begin
         state_q        <= state_d;
         ptr_q          <= ptr_d;
         id_q           <= id_d;
         op_q           <= op_d;
         b_q            <= b_d;
         cnt_q          <= cnt_d;
         req_ack_q      <= req_ack_d;
         fpu_start_q    <= fpu_start_d;
         fpu_op_q       <= fpu_op_d;
         fpu_float_in_q <= fpu_float_in_d;
         fpu_flush_q    <= fpu_flush_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_id_q       <= rsp_id_d;
         rsp_data_q     <= rsp_data_d;
         rsp_err_q      <= rsp_err_d;
         rsp_timeout_q  <= rsp_timeout_d;
         busy_q         <= busy_d;
         op_count_q     <= op_count_d;
      end
   end

   assign req_ack      = req_ack_q;
   assign fpu_start    = fpu_start_q;
   assign fpu_op       = fpu_op_q;
   assign fpu_float_in = fpu_float_in_q;
   assign fpu_flush    = fpu_flush_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_id       = rsp_id_q;
   assign rsp_data     = rsp_data_q;
   assign rsp_err      = rsp_err_q;
   assign rsp_timeout  = rsp_timeout_q;
   assign busy         = busy_q;
   assign op_count     = op_count_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_fpu_op_arbiter.sv
// Bench for fpu_op_arbiter: vector table of single operations, a behavioural
// FPU element, and hand sequences for round-robin, late ready and mid-op reset.
module tb_fpu_op_arbiter;
   import mpu_data_types::*;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 64;
   localparam int CNTW    = 16;
   localparam int IDW     = 2;
   localparam int W       = IDW + 34;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*2-1:0]    req_op;
   logic [NREQ*32-1:0]   req_a, req_b;
   logic [NREQ-1:0]      req_ack;
   logic                 fpu_start, fpu_flush, fpu_ready, fpu_error;
   logic [1:0]           fpu_op;
   logic [31:0]          fpu_float_in, fpu_answer;
   logic                 rsp_valid, rsp_err, rsp_timeout, busy;
   logic [IDW-1:0]       rsp_id;
   logic [31:0]          rsp_data;
   logic [CNTW-1:0]      op_count;
   fpu_arb_state_e       dbg_state;

   fpu_op_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst_n), .req_valid(req_valid), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_ack(req_ack), .fpu_start(fpu_start),
      .fpu_op(fpu_op), .fpu_float_in(fpu_float_in), .fpu_flush(fpu_flush),
      .fpu_answer(fpu_answer), .fpu_ready(fpu_ready), .fpu_error(fpu_error),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
      .op_count(op_count), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   logic [W-1:0] exp_q[$];
   int           exp_cnt = 0;
   int           rsp_cnt = 0, start_cnt = 0;
   int           rsp_cyc = 0, start_cyc = 0, ack_cyc = 0, ack_id = 0;
   int           ack_log[$];

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      exp_q.delete();
      exp_cnt   = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- FPU element model ----------------
   int          model_k   = 3;
   bit          model_err = 1'b0;
   bit          model_xor = 1'b0;
   logic [31:0] model_ans = '0;
   logic [31:0] a_cap = '0, b_cap = '0;

   initial begin
      fpu_ready  = 1'b0;
      fpu_error  = 1'b0;
      fpu_answer = '0;
      forever begin
         @(negedge clk);
         if (rst_n && fpu_start) begin
            a_cap = fpu_float_in;
            @(negedge clk);
            b_cap = fpu_float_in;
            if (model_k >= 3) begin
               repeat (model_k - 2) @(negedge clk);
               fpu_ready  = 1'b1;
               fpu_error  = model_err;
               fpu_answer = model_xor ? (a_cap ^ b_cap) : model_ans;
               @(negedge clk);
               fpu_ready  = 1'b0;
               fpu_error  = 1'b0;
               fpu_answer = '0;
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (req_ack != '0) begin
               chk("ack_onehot", 128'($onehot(req_ack)), 128'(1));
               for (int i = 0; i < NREQ; i++) begin
                  if (req_ack[i]) begin
                     ack_log.push_back(i);
                     ack_cyc      = cyc;
                     ack_id       = i;
                     req_valid[i] = 1'b0;
                  end
               end
            end
            if (fpu_start) begin
               start_cnt++;
               start_cyc = cyc;
            end
            if (!busy || rsp_valid)
               chk("idle_bus_zero", {fpu_float_in, fpu_op, fpu_start}, '0);
            if (rsp_valid) begin
               rsp_cnt++;
               rsp_cyc = cyc;
               exp_cnt++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_rsp actual id=%0d data=%h required none", rsp_id, rsp_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("rsp_fields", {rsp_id, rsp_data, rsp_err, rsp_timeout}, e);
                  chk("rsp_flush", fpu_flush, e[0]);
                  chk("op_count", op_count, exp_cnt);
               end
            end else begin
               chk("rsp_idle_zero", {rsp_id, rsp_data, rsp_err, rsp_timeout, fpu_flush}, '0);
            end
         end
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      int          id;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          k;
      bit          err;
      logic [31:0] ans;
      logic [31:0] exp_data;
      bit          exp_err;
      bit          exp_to;
      int          lat;
   } vec_t;

   vec_t tbl[7];

   task automatic run_vec(input vec_t v);
      int t0, s0, n0, w;
      @(negedge clk);
      model_k   = v.k;
      model_err = v.err;
      model_ans = v.ans;
      model_xor = 1'b0;
      t0 = cyc;
      s0 = start_cnt;
      n0 = rsp_cnt;
      req_op[v.id*2 +: 2]  = v.op;
      req_a[v.id*32 +: 32] = v.a;
      req_b[v.id*32 +: 32] = v.b;
      req_valid[v.id]      = 1'b1;
      exp_q.push_back({IDW'(v.id), v.exp_data, v.exp_err, v.exp_to});
      w = 0;
      while (rsp_cnt == n0 && w < TIMEOUT + 20) begin
         @(negedge clk);
         w++;
      end
      if (rsp_cnt == n0) begin
         checks++;
         errors++;
         $display("FAIL rsp_wait actual none required rsp for id %0d", v.id);
      end
      repeat (3) @(negedge clk);
      chk("rsp_latency", 128'(rsp_cyc - t0), 128'(v.lat));
      chk("ack_latency", 128'(ack_cyc - t0), 128'(1));
      chk("ack_id", 128'(ack_id), 128'(v.id));
      chk("start_count", 128'(start_cnt - s0), (v.op == 2'b00) ? 128'(0) : 128'(1));
      if (v.op != 2'b00) begin
         chk("start_latency", 128'(start_cyc - t0), 128'(1));
         chk("operands", {a_cap, b_cap}, {v.a, v.b});
      end
      chk("exp_q_drained", 128'(exp_q.size()), 128'(0));
      chk("idle_after", {busy, 3'(dbg_state)}, '0);
   endtask

   task automatic wait_rsps(input int target, input string name);
      int w = 0;
      while (rsp_cnt < target && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk(name, 128'(rsp_cnt), 128'(target));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n0;
      logic [31:0] ra, rb;
      int exp_order[6];
      exp_order = '{0, 1, 2, 3, 1, 3};
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;

      //       id op     a             b             k            err ans           exp_data      err to lat
      tbl[0] = '{0, 2'b01, 32'h3F80_0000, 32'h4000_0000, 5,          0, 32'h4040_0000, 32'h4040_0000, 0, 0, 6};
      tbl[1] = '{1, 2'b11, 32'h1111_1111, 32'h2222_2222, 3,          1, 32'h1234_5678, 32'hFFFF_FFFF, 1, 0, 4};
      tbl[2] = '{2, 2'b00, 32'hDEAD_BEEF, 32'hCAFE_F00D, 3,          0, 32'h5555_5555, 32'h0000_0000, 0, 0, 1};
      tbl[3] = '{3, 2'b10, 32'h4120_0000, 32'h4130_0000, 0,          0, 32'h0,         32'hFFFF_FFFF, 1, 1, TIMEOUT + 3};
      tbl[4] = '{1, 2'b01, 32'h0000_0001, 32'h0000_0002, TIMEOUT + 2, 0, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 0, 0, TIMEOUT + 3};
      tbl[5] = '{2, 2'b10, 32'h7F7F_FFFF, 32'h0080_0000, 3,          0, 32'h0BAD_F00D, 32'h0BAD_F00D, 0, 0, 4};
      tbl[6] = '{0, 2'b11, 32'hC000_0000, 32'h3F00_0000, TIMEOUT + 3, 0, 32'h1357_9BDF, 32'hFFFF_FFFF, 1, 1, TIMEOUT + 3};

      rst_n = 1'b0;
      #12;
      chk("reset_outputs",
          {req_ack, fpu_start, fpu_op, fpu_float_in, fpu_flush, rsp_valid, rsp_id,
           rsp_data, rsp_err, rsp_timeout, busy, op_count, 3'(dbg_state)}, '0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) run_vec(tbl[i]);

      // Spurious ready while idle must not produce a response.
      n0 = rsp_cnt;
      @(negedge clk);
      fpu_answer = 32'h7777_7777;
      fpu_ready  = 1'b1;
      repeat (3) @(negedge clk);
      fpu_ready  = 1'b0;
      fpu_answer = '0;
      repeat (3) @(negedge clk);
      chk("late_ready_ignored", {32'(rsp_cnt), 1'(busy)}, {32'(n0), 1'b0});

      // Round-robin: all four, then requesters 1 and 3.
      do_reset();
      ack_log.delete();
      n0 = rsp_cnt;
      model_k   = 3;
      model_err = 1'b0;
      model_xor = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
         ra = $urandom;
         rb = $urandom;
         req_op[i*2 +: 2]  = 2'b01;
         req_a[i*32 +: 32] = ra;
         req_b[i*32 +: 32] = rb;
         req_valid[i]      = 1'b1;
         exp_q.push_back({IDW'(i), ra ^ rb, 1'b0, 1'b0});
      end
      wait_rsps(n0 + 4, "rr_four_rsps");
      @(negedge clk);
      for (int i = 1; i < NREQ; i += 2) begin
         ra = 32'(i) * 32'h0101_0101;
         rb = $urandom_range(1, 1000);
         req_op[i*2 +: 2]  = 2'b10;
         req_a[i*32 +: 32] = ra;
         req_b[i*32 +: 32] = rb;
         req_valid[i]      = 1'b1;
         exp_q.push_back({IDW'(i), ra ^ rb, 1'b0, 1'b0});
      end
      wait_rsps(n0 + 6, "rr_pair_rsps");
      repeat (2) @(negedge clk);
      chk("rr_ack_count", 128'(ack_log.size()), 128'(6));
      if (ack_log.size() == 6)
         for (int i = 0; i < 6; i++) chk("rr_grant_order", 128'(ack_log[i]), 128'(exp_order[i]));

      // Reset during WAIT: outputs clear at once, nothing stale afterwards.
      model_xor = 1'b0;
      model_k   = 0;
      @(negedge clk);
      req_op[1*2 +: 2]  = 2'b10;
      req_a[1*32 +: 32] = 32'h1234_0000;
      req_b[1*32 +: 32] = 32'h0000_4321;
      req_valid[1]      = 1'b1;
      repeat (8) @(negedge clk);
      chk("mid_op_in_wait", 128'(dbg_state), 128'(ARB_WAIT));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs",
          {req_ack, fpu_start, fpu_op, fpu_float_in, fpu_flush, rsp_valid, rsp_id,
           rsp_data, rsp_err, rsp_timeout, busy, op_count, 3'(dbg_state)}, '0);
      req_valid = '0;
      exp_q.delete();
      exp_cnt = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n0 = rsp_cnt;
      repeat (6) @(negedge clk);
      chk("no_stale_rsp", 128'(rsp_cnt), 128'(n0));
      ack_log.delete();
      model_k   = 4;
      model_xor = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NREQ; i += 2) begin
         ra = $urandom;
         rb = $urandom;
         req_op[i*2 +: 2]  = 2'b11;
         req_a[i*32 +: 32] = ra;
         req_b[i*32 +: 32] = rb;
         req_valid[i]      = 1'b1;
         exp_q.push_back({IDW'(i), ra ^ rb, 1'b0, 1'b0});
      end
      wait_rsps(n0 + 2, "post_reset_rsps");
      repeat (2) @(negedge clk);
      chk("post_reset_ack_count", 128'(ack_log.size()), 128'(2));
      if (ack_log.size() == 2)
         chk("post_reset_first_grant", {32'(ack_log[0]), 32'(ack_log[1])}, {32'd0, 32'd2});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
